// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers. A MULT/MULTU/DIV/DIVU takes WIDTH shift steps on operand
// magnitudes followed by one sign-fix cycle. HI/LO are written when the unit
// leaves FIX, and done pulses for one cycle at that point.
//
// Ports:
//   clk      clock, rising edge
//   reset_n  synchronous reset, active low (clears HI/LO and aborts any op)
//   start    start request; accepted in IDLE and on the edge leaving FIX
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     rs/rt operands, sampled only on the accepting edge
//   hi_we    MTHI: HI <= wd (idle only)
//   lo_we    MTLO: LO <= wd (idle only)
//   wd       MTHI/MTLO write data
//   busy     operation in progress
//   done     one-cycle pulse once HI/LO hold a new result
//   hi, lo   HI/LO register outputs
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic             is_div, sign_q, sign_r, div_zero;
    logic [WIDTH-1:0] a_raw, mcand, acc_hi, acc_lo;

    // Two's-complement negate on request; used for |x| and for the sign fix.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                     input logic n);
        return n ? -v : v;
    endfunction

    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    signed_op, a_neg, b_neg, load;
    logic [WIDTH-1:0]        a_mag, b_mag;

    assign a_s       = a;
    assign b_s       = b;
    assign signed_op = ~op[0];
    assign a_neg     = signed_op && (a_s < 0);
    assign b_neg     = signed_op && (b_s < 0);
    assign a_mag     = cond_neg(a, a_neg);
    assign b_mag     = cond_neg(b, b_neg);
    // A new op may also be accepted on the edge that retires the previous one.
    assign load      = start && (state == IDLE || state == FIX);
    assign busy      = (state != IDLE);

    // Multiply step: conditional add into the upper half, then shift the
    // 2*WIDTH+1 bit {carry, acc_hi, acc_lo} right by one.
    logic [WIDTH:0]   mul_sum;
    // Divide step (restoring): the quotient bits shift into acc_lo from the
    // right while dividend bits leave it on the left into the remainder.
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand};
        div_fits  = ~div_diff[WIDTH];
        if (is_div) begin
            step_hi = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_fits};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        prod   = cond_neg2({acc_hi, acc_lo}, sign_q);
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = cond_neg(acc_hi, sign_r);
                res_lo = cond_neg(acc_lo, sign_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // count is loaded with WIDTH: WIDTH step cycles run while count is
    // non-zero, and one more RUN cycle at zero hands over to FIX, which
    // places the HI/LO write on the 34th edge after start for WIDTH=32.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (count == '0) state_nx = FIX;
            FIX:     state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= (state == FIX);
            if (load)
                count <= CW'(WIDTH);
            else if (state == RUN && count != '0)
                count <= count - CW'(1);
            if (state == FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == IDLE) begin
                if (hi_we) hi <= wd;
                if (lo_we) lo <= wd;
            end
        end
    end

    // Operand capture / iteration datapath (no reset: always loaded before use).
    always_ff @(posedge clk) begin
        if (load) begin
            is_div   <= op[1];
            a_raw    <= a;
            div_zero <= op[1] && (b == '0);
            sign_q   <= a_neg ^ b_neg;
            sign_r   <= a_neg;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? a_mag : b_mag;
            mcand    <= op[1] ? b_mag : a_mag;
        end else if (state == RUN && count != '0) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

endmodule
